// File: rtl/aca_pkg.sv
// Shared definitions for the almost-correct adder (ACA) error-recovery stage.
//   aca_state_e : FSM states of aca_error_recovery
//   ACA_WIDTH   : default operand/sum width (must be even)
//   ACA_WINDOW  : default speculation window of the upstream ACA
package aca_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    FIX_LO,
    FIX_HI,
    HOLD
  } aca_state_e;

  localparam int ACA_WIDTH  = 32;
  localparam int ACA_WINDOW = 8;

endpackage

// File: rtl/aca_error_detect.sv
// Conservative speculation-error detector for an ACA with a WINDOW-bit carry
// window. Raises flag_o when a run of WINDOW-1 consecutive propagate bits
// starts at bit 1 or above, so a carry may have travelled further than the
// speculative adder looked. Such a run starting at bit 0 cannot be fed by a
// carry and is not flagged. False positives are acceptable; misses are not.
// Ports:
//   a_i, b_i : operands (WIDTH bits)
//   flag_o   : 1 = speculative result may be wrong
module aca_error_detect
  import aca_pkg::*;
#(
  parameter int WIDTH  = ACA_WIDTH,
  parameter int WINDOW = ACA_WINDOW
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             flag_o
);

  localparam int NRUN = WIDTH - WINDOW + 1;

  logic [WIDTH-1:0] p;
  logic [NRUN-1:0]  run;
  logic             unused_p0;

  assign p = a_i ^ b_i;

  // A propagate at bit 0 never extends a chain (carry-in is 0).
  assign unused_p0 = p[0];

  for (genvar k = 1; k <= NRUN; k++) begin : g_run
    assign run[k-1] = &p[k +: WINDOW-1];
  end

  assign flag_o = |run;

endmodule

// File: rtl/aca_error_recovery.sv
// Error-recovery stage behind a 32-bit almost-correct adder. Accepts operands
// plus the speculative sum/carry, flags possible speculation errors, and when
// correction is enabled recomputes the exact sum in two half-width cycles.
// Results are held under a valid/ready handshake.
// Ports:
//   clk_i, reset_n_i            : clock, async active-low reset
//   valid_i / ready_o           : request handshake
//   input1_i, input2_i          : operands
//   approx_sum_i/approx_carry_i : speculative ACA result
//   correct_en_i                : 1 = recompute flagged results
//   valid_o / ready_i           : result handshake
//   sum_o, carry_o              : result
//   error_o                     : detector flag for this result
//   corrected_o                 : result was recomputed exactly
//
// state  | meaning
// IDLE   | waiting for a request, ready_o=1
// CHECK  | evaluate detector on registered operands
// FIX_LO | add low operand halves, keep half carry
// FIX_HI | add high halves + half carry, load exact result
// HOLD   | present result until ready_i
module aca_error_recovery
  import aca_pkg::*;
#(
  parameter int WIDTH  = ACA_WIDTH,
  parameter int WINDOW = ACA_WINDOW
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] input1_i,
  input  logic [WIDTH-1:0] input2_i,
  input  logic [WIDTH-1:0] approx_sum_i,
  input  logic             approx_carry_i,
  input  logic             correct_en_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             error_o,
  output logic             corrected_o
);

  localparam int HW = WIDTH / 2;

  aca_state_e       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] asum_q;
  logic             acarry_q;
  logic             cen_q;
  logic [HW-1:0]    lo_q;
  logic             half_c_q;
  logic             flag;
  logic             accept;
  logic [HW:0]      lo_full;
  logic [HW:0]      hi_full;

  aca_error_detect #(
    .WIDTH  (WIDTH),
    .WINDOW (WINDOW)
  ) u_detect (
    .a_i    (a_q),
    .b_i    (b_q),
    .flag_o (flag)
  );

  assign ready_o = (state == IDLE) || ((state == HOLD) && ready_i);
  assign accept  = valid_i && ready_o;

  assign lo_full = {1'b0, a_q[HW-1:0]} + {1'b0, b_q[HW-1:0]};
  assign hi_full = {1'b0, a_q[WIDTH-1:HW]} + {1'b0, b_q[WIDTH-1:HW]}
                 + {{HW{1'b0}}, half_c_q};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      asum_q      <= '0;
      acarry_q    <= 1'b0;
      cen_q       <= 1'b0;
      lo_q        <= '0;
      half_c_q    <= 1'b0;
      valid_o     <= 1'b0;
      sum_o       <= '0;
      carry_o     <= 1'b0;
      error_o     <= 1'b0;
      corrected_o <= 1'b0;
    end else begin
      // Operand capture is shared by IDLE and the drain-and-accept in HOLD.
      if (accept) begin
        a_q      <= input1_i;
        b_q      <= input2_i;
        asum_q   <= approx_sum_i;
        acarry_q <= approx_carry_i;
        cen_q    <= correct_en_i;
      end

      case (state)
        IDLE: begin
          if (valid_i) state <= CHECK;
        end

        CHECK: begin
          error_o <= flag;
          if (!flag || !cen_q) begin
            sum_o       <= asum_q;
            carry_o     <= acarry_q;
            corrected_o <= 1'b0;
            valid_o     <= 1'b1;
            state       <= HOLD;
          end else begin
            state <= FIX_LO;
          end
        end

        FIX_LO: begin
          lo_q     <= lo_full[HW-1:0];
          half_c_q <= lo_full[HW];
          state    <= FIX_HI;
        end

        FIX_HI: begin
          sum_o       <= {hi_full[HW-1:0], lo_q};
          carry_o     <= hi_full[HW];
          corrected_o <= 1'b1;
          valid_o     <= 1'b1;
          state       <= HOLD;
        end

        HOLD: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            state   <= valid_i ? CHECK : IDLE;
          end
        end

        default: begin
          valid_o <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aca_error_recovery.sv
module tb_aca_error_recovery;

  logic        clk_i;
  logic        reset_n_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] input1_i;
  logic [31:0] input2_i;
  logic [31:0] approx_sum_i;
  logic        approx_carry_i;
  logic        correct_en_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] sum_o;
  logic        carry_o;
  logic        error_o;
  logic        corrected_o;

  aca_error_recovery #(.WIDTH(32), .WINDOW(8)) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .input1_i       (input1_i),
    .input2_i       (input2_i),
    .approx_sum_i   (approx_sum_i),
    .approx_carry_i (approx_carry_i),
    .correct_en_i   (correct_en_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .sum_o          (sum_o),
    .carry_o        (carry_o),
    .error_o        (error_o),
    .corrected_o    (corrected_o)
  );

  typedef struct {
    logic [31:0] sum;
    logic        carry;
    logic        err;
    logic        corr;
    int          lat;
    int          t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic prev_v = 1'b0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc += 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks += 1;
    if (act !== exp_v) begin
      errors += 1;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] s, input logic c, input logic e,
                              input logic k, input int lat);
    exp_t r;
    r.sum = s; r.carry = c; r.err = e; r.corr = k; r.lat = lat; r.t = 0;
    return r;
  endfunction

  // Monitor: compare each result the first cycle it is presented.
  always @(negedge clk_i) begin
    if (!reset_n_i) begin
      prev_v = 1'b0;
    end else begin
      if (valid_o && !prev_v) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sum", {32'd0, sum_o}, {32'd0, e.sum});
          chk("carry", {63'd0, carry_o}, {63'd0, e.carry});
          chk("error", {63'd0, error_o}, {63'd0, e.err});
          chk("corrected", {63'd0, corrected_o}, {63'd0, e.corr});
          chk("latency", 64'(cyc + 1 - e.t), 64'(e.lat));
        end
      end
      prev_v = valid_o;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] as,
                      input logic ac, input logic cen, input exp_t e);
    logic rdy;
    logic accepted;
    @(negedge clk_i);
    input1_i       = a;
    input2_i       = b;
    approx_sum_i   = as;
    approx_carry_i = ac;
    correct_en_i   = cen;
    valid_i        = 1'b1;
    ready_i        = 1'b1;
    accepted       = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1 rdy = ready_o;
      @(posedge clk_i);
      if (rdy) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    #1;
    valid_i = 1'b0;
    if (accepted) begin
      e.t = cyc;
      q.push_back(e);
    end else begin
      chk("accept_timeout", 64'd0, 64'd1);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() > 0; i++) @(posedge clk_i);
    chk("drain_timeout", 64'(q.size()), 64'd0);
    @(posedge clk_i);
  endtask

  initial begin
    reset_n_i      = 1'b0;
    valid_i        = 1'b0;
    ready_i        = 1'b1;
    input1_i       = '0;
    input2_i       = '0;
    approx_sum_i   = '0;
    approx_carry_i = 1'b0;
    correct_en_i   = 1'b0;

    #1;
    chk("rst_valid", {63'd0, valid_o}, 64'd0);
    chk("rst_sum", {32'd0, sum_o}, 64'd0);
    chk("rst_carry", {63'd0, carry_o}, 64'd0);
    chk("rst_error", {63'd0, error_o}, 64'd0);
    chk("rst_corrected", {63'd0, corrected_o}, 64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    chk("rst_ready", {63'd0, ready_o}, 64'd1);

    // Directed vectors: a, b, approx_sum, approx_carry, correct_en, expected.
    send(32'h0000_0003, 32'h0000_0005, 32'h0000_0008, 1'b0, 1'b1, mk(32'h0000_0008, 1'b0, 1'b0, 1'b0, 2));
    drain();
    send(32'h0000_00FF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, mk(32'h0000_0100, 1'b0, 1'b1, 1'b1, 4));
    drain();
    send(32'h0000_00FF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, mk(32'h0000_0000, 1'b0, 1'b1, 1'b0, 2));
    drain();
    send(32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, mk(32'h0000_0000, 1'b1, 1'b1, 1'b1, 4));
    drain();
    // Seven propagates starting at bit 0: not a hazard.
    send(32'h0000_007F, 32'h0000_0000, 32'h0000_007F, 1'b0, 1'b1, mk(32'h0000_007F, 1'b0, 1'b0, 1'b0, 2));
    drain();
    // Topmost window position bits 25..31.
    send(32'hFE00_0000, 32'h0000_0000, 32'hFE00_0000, 1'b0, 1'b1, mk(32'hFE00_0000, 1'b0, 1'b1, 1'b1, 4));
    drain();
    // Only six propagates at the top: not flagged.
    send(32'hFC00_0000, 32'h0000_0000, 32'hFC00_0000, 1'b0, 1'b1, mk(32'hFC00_0000, 1'b0, 1'b0, 1'b0, 2));
    drain();
    // Fast path passes the speculative carry through.
    send(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, mk(32'h0000_0000, 1'b1, 1'b0, 1'b0, 2));
    drain();
    // False positive across the half boundary, still exact.
    send(32'h0000_FF00, 32'h0000_00FF, 32'h0000_FFFF, 1'b0, 1'b1, mk(32'h0000_FFFF, 1'b0, 1'b1, 1'b1, 4));
    drain();

    // Backpressure, then drain-and-accept in the same cycle.
    send(32'h0000_00FF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, mk(32'h0000_0100, 1'b0, 1'b1, 1'b1, 4));
    ready_i = 1'b0;
    for (int i = 0; i < 20 && !valid_o; i++) @(negedge clk_i);
    chk("bp_valid_seen", {63'd0, valid_o}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("bp_valid", {63'd0, valid_o}, 64'd1);
      chk("bp_ready", {63'd0, ready_o}, 64'd0);
      chk("bp_sum", {32'd0, sum_o}, 64'h100);
      chk("bp_corrected", {63'd0, corrected_o}, 64'd1);
    end
    send(32'h0000_0003, 32'h0000_0005, 32'h0000_0008, 1'b0, 1'b1, mk(32'h0000_0008, 1'b0, 1'b0, 1'b0, 2));
    drain();

    // Asynchronous reset during FIX_HI.
    send(32'h0000_00FF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, mk(32'h0000_0100, 1'b0, 1'b1, 1'b1, 4));
    @(negedge clk_i);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("pre_rst_error", {63'd0, error_o}, 64'd1);
    chk("pre_rst_sum", {32'd0, sum_o}, 64'h8);
    #1 reset_n_i = 1'b0;
    #1;
    chk("arst_valid", {63'd0, valid_o}, 64'd0);
    chk("arst_sum", {32'd0, sum_o}, 64'd0);
    chk("arst_error", {63'd0, error_o}, 64'd0);
    chk("arst_corrected", {63'd0, corrected_o}, 64'd0);
    q.delete();
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_ready", {63'd0, ready_o}, 64'd1);
    for (int i = 0; i < 8; i++) @(negedge clk_i);
    chk("post_rst_no_result", {63'd0, valid_o}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aca_error_recovery.md
Name: aca_error_recovery

Overview:
Downstream stage of the 32-bit almost-correct adder (ACA). It takes the operands together with the speculative sum and carry the ACA produced. It flags any operand pair whose propagate chain may have exceeded the speculation window. When correction is enabled, it recomputes the exact result over two extra half-width cycles, giving a variable-latency, valid/ready-handshaked accurate adder result.

Parameters:
WIDTH, 32, operand/sum width; must be even.
WINDOW, 8, ACA speculation window (bits per sum-bit carry chain); 2 <= WINDOW <= WIDTH.

Ports:
clk_i  input  1  clock, rising edge
reset_n_i  input  1  asynchronous active-low reset
valid_i  input  1  upstream request
ready_o  output  1  block can accept this cycle
input1_i  input  WIDTH  operand A
input2_i  input  WIDTH  operand B
approx_sum_i  input  WIDTH  speculative ACA sum
approx_carry_i  input  1  speculative ACA carry-out
correct_en_i  input  1  1 = correct flagged results, 0 = pass speculative result
valid_o  output  1  result valid
ready_i  input  1  downstream accepts result
sum_o  output  WIDTH  result sum
carry_o  output  1  result carry-out
error_o  output  1  detector flagged possible speculation error
corrected_o  output  1  result was recomputed exactly

Behaviour:
- Reset (async, reset_n_i=0): state IDLE; valid_o=0, sum_o=0, carry_o=0, error_o=0, corrected_o=0; all operand registers cleared. Any in-flight transaction is dropped. ready_o=1 from the first clock after release.
- Accept: on a rising edge with valid_i & ready_o, the block registers input1_i, input2_i, approx_sum_i, approx_carry_i and correct_en_i. Inputs are ignored at all other times.
- Detection: p[k] = a[k]^b[k]. The flag is raised if there exists k with 1 <= k <= WIDTH-WINDOW+1 such that p[k..k+WINDOW-2] are all 1 (a run of WINDOW-1 propagates not starting at bit 0).
  - This detector is conservative: false positives are allowed and only cost latency. False negatives are not allowed.
- States:
  - IDLE: ready_o=1. On accept -> CHECK.
  - CHECK: evaluate the flag on the registered operands and register it into error_o.
    - Flag=0 or registered correct_en=0: load approx sum/carry into the outputs, corrected_o=0 -> HOLD.
    - Otherwise -> FIX_LO.
  - FIX_LO: low half = a[WIDTH/2-1:0] + b[WIDTH/2-1:0] with carry-in 0. Register the low sum bits and the half carry -> FIX_HI.
  - FIX_HI: high half = upper operand halves + registered half carry. Load the exact {sum, carry} into the outputs, corrected_o=1 -> HOLD.
  - HOLD: valid_o=1. sum_o, carry_o, error_o and corrected_o stay stable until ready_i.
    - On ready_i: if valid_i is also high, accept the new request in the same cycle -> CHECK; otherwise -> IDLE.
- ready_o = (state==IDLE) | (state==HOLD & ready_i).
- Latency from the accept edge t: valid_o is asserted from t+2 (fast path) or t+4 (corrected path).
- Arithmetic is unsigned modulo 2^WIDTH; carry_o is bit WIDTH of the sum.
- The outputs keep their last values after a handshake until they are reloaded. valid_o=0 outside HOLD.

Decomposition:
- Shared package aca_pkg:
  - state enum {IDLE, CHECK, FIX_LO, FIX_HI, HOLD}
  - default constants ACA_WIDTH=32 and ACA_WINDOW=8
- Sub-module aca_error_detect: combinational propagate-run detector, parameters WIDTH and WINDOW, inputs the two operands, output the 1-bit flag.
- The FSM, half-adders and registers live in the top module.

Test Plan (WIDTH=32, WINDOW=8):
1. input1=0x00000003, input2=0x00000005, approx_sum=0x00000008, correct_en=1, accept at t -> valid_o at t+2; sum_o=0x00000008, carry_o=0, error_o=0, corrected_o=0.
2. input1=0x000000FF, input2=0x00000001, approx_sum=0x00000000, correct_en=1 -> flagged (p[1..7]=1); valid_o at t+4; sum_o=0x00000100, carry_o=0, error_o=1, corrected_o=1.
3. Same as 2 with correct_en=0 -> valid_o at t+2; sum_o=0x00000000, error_o=1, corrected_o=0.
4. input1=0xFFFFFFFF, input2=0x00000001, approx_sum=0x00000000, approx_carry=0, correct_en=1 -> valid_o at t+4; sum_o=0x00000000, carry_o=1, corrected_o=1.
5. Backpressure: hold ready_i=0 for 5 cycles in HOLD -> outputs stable, ready_o=0. Then ready_i=1 with valid_i=1 carrying test-1 operands -> drain and accept in the same cycle; the next valid_o two cycles later.
6. Assert reset_n_i low during FIX_HI of test 2 -> valid_o, sum_o, error_o and corrected_o go to 0 immediately (no clock edge needed). After release: ready_o=1 and no stale result appears.
